ser_addr_seq: RTL

Controller and capture stage that sits directly downstream of the 74LS165-style parallel-in/serial-out shifters on the serial address bus. On a start request it drives the active-low parallel-load strobe, issues a burst of serial clock pulses, and samples both serial lanes (high byte, low byte). It then presents the reassembled 16-bit address with a one-cycle valid strobe to the memory-cycle logic. It generates shld and serclk itself, so it is the single owner of serial-bus timing.

---
 rtl/ser_bus_pkg.sv | 24 ++
 rtl/ser_lane_capture.sv | 35 +++
 rtl/ser_addr_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ser_bus_pkg.sv
// ============================================================================
//  ser_bus_pkg
//  Shared state encoding and default sizing for the serial address bus.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ser_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ser_state_e;

    localparam int SER_WIDTH    = 8;
    localparam int SER_DIV      = 1;
    localparam int SER_LOAD_CYC = 1;
    localparam int ADDR_W       = 2 * SER_WIDTH;

endpackage

`default_nettype wire

// File: rtl/ser_lane_capture.sv
// ============================================================================
//  ser_lane_capture
//  MSB-first serial capture register for one shifter lane.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ser_lane_capture #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             sdin,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (clear) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= {r_q[WIDTH-2:0], sdin};
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/ser_addr_seq.sv
// ============================================================================
//  ser_addr_seq
//  Drives shld/serclk for two 74LS165-style shifters and reassembles the
//  16-bit address from the high and low serial lanes.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ser_addr_seq
    import ser_bus_pkg::*;
#(
    parameter int WIDTH    = SER_WIDTH,
    parameter int DIV      = SER_DIV,
    parameter int LOAD_CYC = SER_LOAD_CYC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sdin_hi,
    input  logic               sdin_lo,
    output logic               shld,
    output logic               serclk,
    output logic [2*WIDTH-1:0] address,
    output logic               valid,
    output logic               busy
);

    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int PH_W  = $clog2(DIV + 1);
    localparam int LD_W  = $clog2(LOAD_CYC + 1);

    // Reset asserts immediately but releases only on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    ser_state_e         r_state, w_state_nxt;
    logic               r_shld, w_shld_nxt;
    logic               r_serclk, w_serclk_nxt;
    logic [BIT_W-1:0]   r_bit, w_bit_nxt;
    logic [PH_W-1:0]    r_ph, w_ph_nxt;
    logic [LD_W-1:0]    r_ld, w_ld_nxt;
    logic [2*WIDTH-1:0] r_address;
    logic               r_valid;
    logic               w_shift_en;
    logic               w_clear;
    logic [WIDTH-1:0]   w_cap_hi;
    logic [WIDTH-1:0]   w_cap_lo;

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state   <= IDLE;
            r_shld    <= 1'b1;
            r_serclk  <= 1'b0;
            r_bit     <= '0;
            r_ph      <= '0;
            r_ld      <= '0;
            r_address <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shld   <= w_shld_nxt;
            r_serclk <= w_serclk_nxt;
            r_bit    <= w_bit_nxt;
            r_ph     <= w_ph_nxt;
            r_ld     <= w_ld_nxt;
            r_valid  <= (r_state == DONE);
            if (r_state == DONE) begin
                r_address <= {w_cap_hi, w_cap_lo};
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shld_nxt   = 1'b1;
        w_serclk_nxt = 1'b0;
        w_bit_nxt    = r_bit;
        w_ph_nxt     = r_ph;
        w_ld_nxt     = r_ld;
        w_shift_en   = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = LOAD;
                    w_shld_nxt  = 1'b0;
                    w_ld_nxt    = '0;
                    w_clear     = 1'b1;
                end
            end
            LOAD: begin
                if (r_ld == LD_W'(LOAD_CYC - 1)) begin
                    w_state_nxt = SHIFT;
                    w_bit_nxt   = '0;
                    w_ph_nxt    = '0;
                end else begin
                    w_shld_nxt = 1'b0;
                    w_ld_nxt   = r_ld + LD_W'(1);
                end
            end
            SHIFT: begin
                w_serclk_nxt = r_serclk;
                if (r_ph == PH_W'(DIV - 1)) begin
                    w_ph_nxt = '0;
                    // Lanes sample on the rising edge we drive; the shifters
                    // only see it one edge later, so sdin is still stable.
                    if (!r_serclk) begin
                        w_serclk_nxt = 1'b1;
                        w_shift_en   = 1'b1;
                    end else begin
                        w_serclk_nxt = 1'b0;
                        w_bit_nxt    = r_bit + BIT_W'(1);
                        if (r_bit == BIT_W'(WIDTH - 1)) begin
                            w_state_nxt = DONE;
                        end
                    end
                end else begin
                    w_ph_nxt = r_ph + PH_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    ser_lane_capture #(.WIDTH(WIDTH)) u_cap_hi (
        .clk      (clk),
        .reset    (w_rst),
        .clear    (w_clear),
        .shift_en (w_shift_en),
        .sdin     (sdin_hi),
        .q        (w_cap_hi)
    );

    ser_lane_capture #(.WIDTH(WIDTH)) u_cap_lo (
        .clk      (clk),
        .reset    (w_rst),
        .clear    (w_clear),
        .shift_en (w_shift_en),
        .sdin     (sdin_lo),
        .q        (w_cap_lo)
    );

    assign shld    = r_shld;
    assign serclk  = r_serclk;
    assign address = r_address;
    assign valid   = r_valid;
    assign busy    = (r_state != IDLE);

endmodule

`default_nettype wire
